ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter that shares the single-port, synchronous data RAM (8 KiB, 2048 × 32-bit words, word index = byte address bits [12:2], one-cycle registered read) between the MIPS core data port and the monitor/debug port. It sits between both masters and the RAM instance. It accepts at most one access per clock, grants round-robin under contention, and routes the read data back to the requester that issued it, one cycle after the grant.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requester ports and the RAM address.
- DATA_W, 32, data width.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  core access request; held with c_we/c_addr/c_wd stable until c_gnt.
- c_we  in  1  core write enable (1 = write, 0 = read).
- c_addr  in  ADDR_W  core byte address.
- c_wd  in  DATA_W  core write data.
- c_gnt  out  1  core access issued to the RAM this cycle (combinational).
- c_rvalid  out  1  core read data valid (registered pulse).
- c_rd  out  DATA_W  core read data, valid when c_rvalid = 1.
- m_req, m_we, m_addr, m_wd, m_gnt, m_rvalid, m_rd: identical set for the monitor port.
- ram_we  out  1  to the RAM we.
- ram_addr  out  ADDR_W  to the RAM addr.
- ram_wd  out  DATA_W  to the RAM wd.
- ram_rd  in  DATA_W  from the RAM rd (registered in the RAM, valid the cycle after the address).

## Operation
- Grant logic (combinational):
  - Only one requester active: that requester is granted.
  - Both active: the requester not recorded in last_gnt is granted.
  - Neither active: no grant; ram_we = 0.
- RAM drive:
  - ram_addr/ram_wd follow the granted requester.
  - ram_we = granted requester's we AND its gnt.
  - With no grant, ram_addr/ram_wd hold the core's values and ram_we = 0.
- last_gnt register (0 = core, 1 = monitor):
  - Updated only on a grant cycle.
  - Reset value 0, so the monitor wins the first tie.
- Read return:
  - A granted read sets rd_pend = 1 and rd_owner = granted id on the next edge.
  - In the following cycle, the matching x_rvalid = 1 and x_rd = ram_rd.
  - The non-owner's rvalid = 0; its rd holds the last value delivered to it. Both rd outputs reset to 0.
- Writes:
  - Completion is signalled by gnt alone; no rvalid.
  - The RAM's read-old-data on a write cycle is discarded.
- Pipelining: a new grant may occur in the same cycle as the rvalid of a previous read, giving back-to-back reads at one per cycle.
- Address:
  - Passed unmodified; the RAM uses only bits [12:2], so higher bits alias.
  - Bits [1:0] are ignored (word accesses only).
- Requester rule: a requester must not change we/addr/wd or drop req while req = 1 and gnt = 0. Violations are undefined and are not checked by the bench.

## Timing
- Reset values: last_gnt = 0, rd_pend = 0, c_rvalid = m_rvalid = 0, c_rd = m_rd = 0.
- While reset = 1:
  - c_gnt = m_gnt = 0 and ram_we = 0.
  - A read granted in the cycle before reset asserts produces no rvalid.
- Uncontended latency:
  - Grant in the cycle req rises (0 wait).
  - Read data at rvalid in cycle +1.
- Contended wait: a losing requester waits at most one cycle.
- Sustained contention strictly alternates grants: C, M, C, M… or M, C, M, C…, depending on last_gnt.
- Throughput: one access per cycle. The RAM is never idle while any req = 1.

## Structure
- Shared include mem_defs.vh holds:
  - port id constants PORT_CORE = 1'b0 and PORT_MON = 1'b1;
  - RAM geometry constants RAM_WORDS = 2048, RAM_WADDR_LSB = 2, RAM_WADDR_MSB = 12.
- One natural sub-module: rr_arb2, a pure 2-way round-robin grant function (inputs req[1:0] and last; output gnt[1:0]).
- The top level holds last_gnt, rd_pend/rd_owner, the muxes, and the rd/rvalid registers.

## Test plan
- Reset then core-only write/read:
  - Core writes 0xDEADBEEF to 0x0000_0010: c_gnt = 1 the same cycle and ram_we = 1.
  - Core then reads 0x10: c_rvalid = 1 one cycle later with c_rd = 0xDEADBEEF, and m_rvalid stays 0.
- First tie after reset:
  - Core reads 0x20 and monitor reads 0x24 simultaneously.
  - m_gnt in cycle 0, c_gnt in cycle 1.
  - m_rvalid in cycle 1, c_rvalid in cycle 2, each carrying its own address's preloaded word.
- Sustained contention, 8 cycles: grants alternate M, C, M, C, M, C, M, C; no cycle with both gnt = 1 or both gnt = 0.
- Aliasing:
  - Monitor writes 0x1234_5678 to 0x0000_2004.
  - Core reads 0x0000_0004 and returns 0x1234_5678; bits [1:0] = 3 read the same word.
- Reset mid-read:
  - Core read granted, then reset asserted the next cycle.
  - c_rvalid stays 0, c_rd = 0, and the next tie grants the monitor first.
- Back-to-back core reads of 0x0, 0x4, 0x8 in consecutive cycles: three consecutive c_rvalid pulses with the matching data, in order.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module : ram_arbiter_pkg
// Brief  : Port identifiers and data-RAM geometry shared by the RAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  // Requester identifiers; also the bit positions in the 2-bit req/gnt vectors
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_MON  = 1'b1;

  localparam int RAM_WORDS     = 2048;
  localparam int RAM_WADDR_LSB = 2;
  localparam int RAM_WADDR_MSB = 12;

  typedef logic [RAM_WADDR_MSB-RAM_WADDR_LSB:0] ram_widx_t;

  // Word index the RAM actually decodes from a byte address
  function automatic ram_widx_t ram_word_index(input logic [31:0] byte_addr);
    return byte_addr[RAM_WADDR_MSB:RAM_WADDR_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Stateless two-way round-robin grant; the caller owns the history.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie goes to whoever did not win the previous grant
      2'b11:   gnt = (last == PORT_MON) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module : ram_arbiter
// Brief  : Shares the single-port data RAM between core and monitor ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wd,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rd,

  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wd,
  output logic              m_gnt,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rd,

  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  input  logic [DATA_W-1:0] ram_rd
);

  logic              r_last_gnt;
  logic              r_rd_pend;
  logic              r_rd_owner;
  logic [DATA_W-1:0] r_c_rd_hold;
  logic [DATA_W-1:0] r_m_rd_hold;

  logic [1:0]        w_req;
  logic [1:0]        w_arb_gnt;
  logic [1:0]        w_gnt;
  logic              w_sel_mon;
  logic              w_any_gnt;

  assign w_req = {m_req, c_req};

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (r_last_gnt),
    .gnt  (w_arb_gnt)
  );

  assign w_gnt     = reset ? 2'b00 : w_arb_gnt;
  assign c_gnt     = w_gnt[PORT_CORE];
  assign m_gnt     = w_gnt[PORT_MON];
  assign w_sel_mon = w_gnt[PORT_MON];
  assign w_any_gnt = |w_gnt;

  // Idle cycles park the RAM bus on the core's address/data
  assign ram_addr = w_sel_mon ? m_addr : c_addr;
  assign ram_wd   = w_sel_mon ? m_wd   : c_wd;
  assign ram_we   = (c_gnt & c_we) | (m_gnt & m_we);

  // Read data arrives from the RAM the cycle after the grant, so the
  // return path is a mux steered by the pending-read record.
  assign c_rvalid = r_rd_pend & (r_rd_owner == PORT_CORE) & ~reset;
  assign m_rvalid = r_rd_pend & (r_rd_owner == PORT_MON)  & ~reset;

  assign c_rd = reset ? '0 : (c_rvalid ? ram_rd : r_c_rd_hold);
  assign m_rd = reset ? '0 : (m_rvalid ? ram_rd : r_m_rd_hold);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt  <= PORT_CORE;
      r_rd_pend   <= 1'b0;
      r_rd_owner  <= PORT_CORE;
      r_c_rd_hold <= '0;
      r_m_rd_hold <= '0;
    end else begin
      if (w_any_gnt) begin
        r_last_gnt <= w_sel_mon;
      end
      r_rd_pend  <= w_any_gnt & ~ram_we;
      r_rd_owner <= w_sel_mon;
      if (c_rvalid) begin
        r_c_rd_hold <= ram_rd;
      end
      if (m_rvalid) begin
        r_m_rd_hold <= ram_rd;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Self-checking bench for ram_arbiter with a behavioural data RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload;
  logic        c_req, c_we, m_req, m_we;
  logic [31:0] c_addr, c_wd, m_addr, m_wd;
  logic        c_gnt, c_rvalid, m_gnt, m_rvalid;
  logic [31:0] c_rd, m_rd;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wd, ram_rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem     [0:RAM_WORDS-1];
  logic [31:0] exp_mem [0:RAM_WORDS-1];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rd(m_rd),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Synchronous RAM with registered read (read-old-data on write)
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < RAM_WORDS; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_word_index(ram_addr)] <= ram_wd;
    end
    ram_rd <= mem[ram_word_index(ram_addr)];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_c(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
    c_req = rq; c_we = we; c_addr = a; c_wd = d;
  endtask

  task automatic set_m(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
    m_req = rq; m_we = we; m_addr = a; m_wd = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; preload = 1'b1;
    set_c(1'b1, 1'b0, 32'h10, 32'h0);
    set_m(1'b1, 1'b1, 32'h14, 32'h1111_1111);
    for (int i = 0; i < RAM_WORDS; i++) exp_mem[i] = pat(i);
    tick();
    preload = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if ({c_gnt, m_gnt, ram_we} !== 3'b000) begin
        n_errors++; $display("FAIL rst_gnt: got c/m/we=%b want 000", {c_gnt, m_gnt, ram_we});
      end
      n_checks++;
      if ({c_rvalid, m_rvalid} !== 2'b00 || c_rd !== 32'h0 || m_rd !== 32'h0) begin
        n_errors++; $display("FAIL rst_rd: got rv=%b c_rd=%h m_rd=%h want 00/0/0", {c_rvalid, m_rvalid}, c_rd, m_rd);
      end
      tick();
    end
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_core_write_read();
    set_c(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    settle();
    n_checks++;
    if (c_gnt !== 1'b1 || m_gnt !== 1'b0 || ram_we !== 1'b1) begin
      n_errors++; $display("FAIL cw_gnt: got c/m/we=%b want 101", {c_gnt, m_gnt, ram_we});
    end
    n_checks++;
    if (ram_addr !== 32'h10 || ram_wd !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL cw_bus: got addr=%h wd=%h want 00000010/deadbeef", ram_addr, ram_wd);
    end
    exp_mem[4] = 32'hDEAD_BEEF;
    tick();
    set_c(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    settle();
    n_checks++;
    if (c_gnt !== 1'b1 || ram_we !== 1'b0 || c_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL cr_issue: got gnt/we/rv=%b want 100", {c_gnt, ram_we, c_rvalid});
    end
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rd !== 32'hDEAD_BEEF || m_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL cr_data: got rv=%b rd=%h m_rv=%b want 1/deadbeef/0", c_rvalid, c_rd, m_rvalid);
    end
    tick();
    settle();
    n_checks++;
    if (c_rvalid !== 1'b0 || c_rd !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL cr_hold: got rv=%b rd=%h want 0/deadbeef", c_rvalid, c_rd);
    end
    tick();
  endtask

  task automatic test_first_tie();
    set_c(1'b1, 1'b0, 32'h20, 32'h0);
    set_m(1'b1, 1'b0, 32'h24, 32'h0);
    settle();
    n_checks++;
    if (m_gnt !== 1'b1 || c_gnt !== 1'b0 || ram_addr !== 32'h24) begin
      n_errors++; $display("FAIL tie_c0: got m/c=%b%b addr=%h want 10/00000024", m_gnt, c_gnt, ram_addr);
    end
    tick();
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    n_checks++;
    if (c_gnt !== 1'b1 || m_rvalid !== 1'b1 || m_rd !== exp_mem[9] || c_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL tie_c1: got cg=%b mrv=%b mrd=%h crv=%b want 1/1/%h/0", c_gnt, m_rvalid, m_rd, c_rvalid, exp_mem[9]);
    end
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rd !== exp_mem[8] || m_rvalid !== 1'b0 || m_rd !== exp_mem[9]) begin
      n_errors++; $display("FAIL tie_c2: got crv=%b crd=%h mrv=%b mrd=%h want 1/%h/0/%h", c_rvalid, c_rd, m_rvalid, m_rd, exp_mem[8], exp_mem[9]);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] ca, ma;
    logic        prev_mon;
    logic [31:0] prev_data;
    ca = {19'b0, 11'($urandom_range(0, RAM_WORDS-1)), 2'b00};
    ma = {19'b0, 11'($urandom_range(0, RAM_WORDS-1)), 2'b00};
    set_c(1'b1, 1'b0, ca, 32'h0);
    set_m(1'b1, 1'b0, ma, 32'h0);
    prev_mon = 1'b0; prev_data = '0;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_checks++;
      if (m_gnt !== ((k % 2) == 0) || c_gnt !== ((k % 2) == 1)) begin
        n_errors++; $display("FAIL cont_gnt[%0d]: got m/c=%b%b want %b%b", k, m_gnt, c_gnt, (k % 2) == 0, (k % 2) == 1);
      end
      if (k > 0) begin
        n_checks++;
        if ((prev_mon ? m_rvalid : c_rvalid) !== 1'b1 || (prev_mon ? m_rd : c_rd) !== prev_data) begin
          n_errors++; $display("FAIL cont_rd[%0d]: got rv=%b rd=%h want 1/%h", k, prev_mon ? m_rvalid : c_rvalid, prev_mon ? m_rd : c_rd, prev_data);
        end
      end
      prev_mon  = ((k % 2) == 0);
      prev_data = prev_mon ? exp_mem[ram_word_index(ma)] : exp_mem[ram_word_index(ca)];
      tick();
    end
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rd !== prev_data || m_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL cont_last: got crv=%b crd=%h mrv=%b want 1/%h/0", c_rvalid, c_rd, m_rvalid, prev_data);
    end
    tick();
  endtask

  task automatic test_aliasing();
    set_m(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678);
    settle();
    n_checks++;
    if (m_gnt !== 1'b1 || ram_we !== 1'b1 || m_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL alias_wr: got gnt/we/rv=%b want 110", {m_gnt, ram_we, m_rvalid});
    end
    exp_mem[1] = 32'h1234_5678;
    tick();
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    set_c(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    settle();
    n_checks++;
    if (c_gnt !== 1'b1) begin
      n_errors++; $display("FAIL alias_rd_gnt: got %b want 1", c_gnt);
    end
    tick();
    set_c(1'b1, 1'b0, 32'h0000_0007, 32'h0);
    settle();
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rd !== 32'h1234_5678 || c_gnt !== 1'b1) begin
      n_errors++; $display("FAIL alias_rd: got rv=%b rd=%h gnt=%b want 1/12345678/1", c_rvalid, c_rd, c_gnt);
    end
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rd !== 32'h1234_5678) begin
      n_errors++; $display("FAIL alias_lsb: got rv=%b rd=%h want 1/12345678", c_rvalid, c_rd);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_c(1'b1, 1'b0, 32'h30, 32'h0);
    settle();
    n_checks++;
    if (c_gnt !== 1'b1) begin
      n_errors++; $display("FAIL rmr_gnt: got %b want 1", c_gnt);
    end
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    settle();
    n_checks++;
    if (c_rvalid !== 1'b0 || c_gnt !== 1'b0) begin
      n_errors++; $display("FAIL rmr_rv_in_rst: got rv=%b gnt=%b want 0/0", c_rvalid, c_gnt);
    end
    tick();
    reset = 1'b0;
    settle();
    n_checks++;
    if (c_rvalid !== 1'b0 || c_rd !== 32'h0 || m_rd !== 32'h0) begin
      n_errors++; $display("FAIL rmr_after: got rv=%b c_rd=%h m_rd=%h want 0/0/0", c_rvalid, c_rd, m_rd);
    end
    tick();
    set_c(1'b1, 1'b0, 32'h30, 32'h0);
    set_m(1'b1, 1'b0, 32'h34, 32'h0);
    settle();
    n_checks++;
    if (m_gnt !== 1'b1 || c_gnt !== 1'b0) begin
      n_errors++; $display("FAIL rmr_tie: got m/c=%b%b want 10", m_gnt, c_gnt);
    end
    tick();
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_c(1'b1, 1'b0, 32'(4 * k), 32'h0);
      else       set_c(1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      if (k < 3) begin
        n_checks++;
        if (c_gnt !== 1'b1) begin
          n_errors++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, c_gnt);
        end
      end
      if (k > 0) begin
        n_checks++;
        if (c_rvalid !== 1'b1 || c_rd !== exp_mem[k-1]) begin
          n_errors++; $display("FAIL b2b_rd[%0d]: got rv=%b rd=%h want 1/%h", k, c_rvalid, c_rd, exp_mem[k-1]);
        end
      end
      tick();
    end
  endtask

  // Randomised traffic against a transaction-level model of the arbiter
  task automatic test_random();
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] padr [2];
    logic [31:0] pwd  [2];
    logic        rv_v [2];
    logic [31:0] rv_d [2];
    logic [31:0] last_rd [2];
    int          last_w;
    int          w;
    reset = 1'b1;
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    last_w = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwe[p] = 1'b0; padr[p] = '0; pwd[p] = '0;
      rv_v[p] = 1'b0; rv_d[p] = '0; last_rd[p] = '0;
    end
    for (int i = 0; i < 401; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && i < 400 && $urandom_range(0, 99) < 60) begin
          pend[p] = 1'b1;
          pwe[p]  = ($urandom_range(0, 2) == 0);
          padr[p] = $urandom;
          pwd[p]  = $urandom;
        end
      end
      set_c(pend[0], pwe[0], padr[0], pwd[0]);
      set_m(pend[1], pwe[1], padr[1], pwd[1]);
      settle();
      if (pend[0] && pend[1]) w = 1 - last_w;
      else if (pend[0])       w = 0;
      else if (pend[1])       w = 1;
      else                    w = -1;
      n_checks++;
      if (c_gnt !== (w == 0) || m_gnt !== (w == 1)) begin
        n_errors++; $display("FAIL rnd_gnt[%0d]: got c/m=%b%b want %b%b", i, c_gnt, m_gnt, w == 0, w == 1);
      end
      n_checks++;
      if (c_rvalid !== rv_v[0] || c_rd !== (rv_v[0] ? rv_d[0] : last_rd[0])) begin
        n_errors++; $display("FAIL rnd_c_rd[%0d]: got rv=%b rd=%h want %b/%h", i, c_rvalid, c_rd, rv_v[0], rv_v[0] ? rv_d[0] : last_rd[0]);
      end
      n_checks++;
      if (m_rvalid !== rv_v[1] || m_rd !== (rv_v[1] ? rv_d[1] : last_rd[1])) begin
        n_errors++; $display("FAIL rnd_m_rd[%0d]: got rv=%b rd=%h want %b/%h", i, m_rvalid, m_rd, rv_v[1], rv_v[1] ? rv_d[1] : last_rd[1]);
      end
      n_checks++;
      if (ram_we !== (w >= 0 && pwe[w >= 0 ? w : 0]) || (w >= 0 && ram_addr !== padr[w >= 0 ? w : 0])) begin
        n_errors++; $display("FAIL rnd_bus[%0d]: got we=%b addr=%h", i, ram_we, ram_addr);
      end
      for (int p = 0; p < 2; p++) begin
        if (rv_v[p]) last_rd[p] = rv_d[p];
        rv_v[p] = 1'b0;
      end
      if (w >= 0) begin
        if (pwe[w]) begin
          exp_mem[ram_word_index(padr[w])] = pwd[w];
        end else begin
          rv_v[w] = 1'b1;
          rv_d[w] = exp_mem[ram_word_index(padr[w])];
        end
        last_w  = w;
        pend[w] = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    preload = 1'b1;
    test_reset();
    test_core_write_read();
    test_first_tie();
    test_contention();
    test_aliasing();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
